// File: rtl/data_ram_responder_pkg.sv
// Shared constants for the data RAM responder: bus geometry, the
// load-latency ceiling and the width of the loads-in-flight counter.
package data_ram_responder_pkg;
  localparam int DATA_WIDTH_G     = 32;
  localparam int LANES            = 4;
  localparam int BYTE_W           = 8;
  localparam int MAX_READ_LATENCY = 4;
  localparam int PEND_W           = 3;
endpackage

// File: rtl/ram_load_pipe.sv
// Valid/index shift pipeline for RAM loads. It exposes the entry that is
// about to land in the final stage, so the top can read the array on that
// same edge. The final-stage valid is the readValid strobe. It also keeps
// the count of loads in flight.
module ram_load_pipe
  import data_ram_responder_pkg::*;
#(
  parameter int LAT = 1,
  parameter int IW  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_accept,
  input  logic [IW-1:0]     i_idx,
  output logic              o_last_in_valid,
  output logic [IW-1:0]     o_last_in_idx,
  output logic              o_read_valid,
  output logic [PEND_W-1:0] o_pending
);

  logic [LAT-1:0]    r_valid;
  logic [IW-1:0]     r_idx [LAT];
  logic [PEND_W-1:0] r_pend;
  logic              w_unused_idx;

  // shift accepted loads toward the final stage and track loads in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_pend  <= '0;
      for (int i = 0; i < LAT; i++) r_idx[i] <= '0;
    end else begin
      r_valid[0] <= i_accept;
      r_idx[0]   <= i_idx;
      for (int i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
      r_pend <= r_pend + PEND_W'(i_accept) - PEND_W'(r_valid[LAT-1]);
    end
  end

  // with a single stage the request itself is what enters the final stage
  if (LAT == 1) begin : g_direct
    assign o_last_in_valid = i_accept;
    assign o_last_in_idx   = i_idx;
  end else begin : g_staged
    assign o_last_in_valid = r_valid[LAT-2];
    assign o_last_in_idx   = r_idx[LAT-2];
  end

  assign o_read_valid = r_valid[LAT-1];
  assign o_pending    = r_pend;
  // the array is read as an index enters the last stage, so its copy there is dead
  assign w_unused_idx = ^r_idx[LAT-1];

endmodule

// File: rtl/data_ram_responder.sv
// Byte-lane data RAM answering the memory controller's store/load requests.
// Loads return through a fixed-latency pipeline with a readValid strobe.
// Optional feature: define RAM_BOUNDS_CHECK_EN to flag out-of-range word
// indices on accessFault, suppress such stores and return 0 for such loads;
// otherwise the word index wraps modulo DEPTH_WORDS.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_G,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           addressIn,
  input  logic [DATA_WIDTH-1:0] dataWriteIn,
  input  logic [LANES-1:0]      byteSelect,
  input  logic                  storeIn,
  input  logic                  loadIn,
  output logic [DATA_WIDTH-1:0] dataReadOut,
  output logic                  readValid,
  output logic [PEND_W-1:0]     loadsPending,
  output logic                  requestConflict
`ifdef RAM_BOUNDS_CHECK_EN
  ,
  output logic                  accessFault
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_run;
  logic                  r_conflict;
  logic [AW-1:0]         w_idx;
  logic                  w_oob;
  logic                  w_store;
  logic                  w_store_en;
  logic                  w_load_acc;
  logic                  w_last_valid;
  logic [AW:0]           w_last_idx;
  logic                  w_unused_addr;

  // requests are ignored until one full edge has passed after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  assign w_idx = addressIn[AW+1:2];

`ifdef RAM_BOUNDS_CHECK_EN
  logic r_fault;
  assign w_oob         = (addressIn[31:2] >= 30'(DEPTH_WORDS));
  assign w_unused_addr = ^addressIn[1:0];

  // one-cycle fault strobe for any honoured access outside the array
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_fault <= 1'b0;
    else        r_fault <= r_run & (storeIn | loadIn) & w_oob;
  end
  assign accessFault = r_fault;
`else
  assign w_oob         = 1'b0;
  assign w_unused_addr = ^{addressIn[1:0], addressIn[31:AW+2]};
`endif

  assign w_store    = r_run & storeIn;
  assign w_store_en = w_store & ~w_oob;
  assign w_load_acc = r_run & loadIn & ~storeIn;

  // per-lane store commit; the array itself is never reset
  always_ff @(posedge clk) begin
    if (w_store_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (byteSelect[i]) r_mem[w_idx][BYTE_W*i +: BYTE_W] <= dataWriteIn[BYTE_W*i +: BYTE_W];
      end
    end
  end

  ram_load_pipe #(
    .LAT (READ_LATENCY),
    .IW  (AW + 1)
  ) u_pipe (
    .clk             (clk),
    .rst_n           (reset),
    .i_accept        (w_load_acc),
    .i_idx           ({w_oob, w_idx}),
    .o_last_in_valid (w_last_valid),
    .o_last_in_idx   (w_last_idx),
    .o_read_valid    (readValid),
    .o_pending       (loadsPending)
  );

  // read the array as a load enters the final stage; hold between loads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_data <= '0;
    else if (w_last_valid) r_data <= w_last_idx[AW] ? '0 : r_mem[w_last_idx[AW-1:0]];
  end

  // flag a store and load sampled together; the load was dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_conflict <= 1'b0;
    else        r_conflict <= r_run & storeIn & loadIn;
  end

  assign dataReadOut     = r_data;
  assign requestConflict = r_conflict;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: two instances (latency 1 and 3) share one
// stimulus stream. A word-array/load-list reference model checks every
// cycle; a directed table and hand sequences pin the documented cases.
module tb_data_ram_responder;

  localparam int DEPTH = 1024;
`ifdef RAM_BOUNDS_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addressIn = '0;
  logic [31:0] dataWriteIn = '0;
  logic [3:0]  byteSelect = '0;
  logic        storeIn = 1'b0;
  logic        loadIn = 1'b0;

  logic [31:0] rd [2];
  logic        rv [2];
  logic [2:0]  lp [2];
  logic        cf [2];
  logic        af [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_ram_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .addressIn(addressIn), .dataWriteIn(dataWriteIn),
    .byteSelect(byteSelect), .storeIn(storeIn), .loadIn(loadIn),
    .dataReadOut(rd[0]), .readValid(rv[0]), .loadsPending(lp[0]),
    .requestConflict(cf[0])
`ifdef RAM_BOUNDS_CHECK_EN
    , .accessFault(af[0])
`endif
  );

  data_ram_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .addressIn(addressIn), .dataWriteIn(dataWriteIn),
    .byteSelect(byteSelect), .storeIn(storeIn), .loadIn(loadIn),
    .dataReadOut(rd[1]), .readValid(rv[1]), .loadsPending(lp[1]),
    .requestConflict(cf[1])
`ifdef RAM_BOUNDS_CHECK_EN
    , .accessFault(af[1])
`endif
  );

`ifndef RAM_BOUNDS_CHECK_EN
  assign af[0] = 1'b0;
  assign af[1] = 1'b0;
`endif

  // ---------------- reference model ----------------
  typedef struct {
    int          dut;
    int          due;
    int unsigned widx;
    bit          oob;
  } ld_t;

  int          lat_of [2] = '{1, 3};
  logic [31:0] mmem [DEPTH];
  ld_t         lq [$];
  int          cyc = 0;
  int          run_cnt = 0;
  bit          exp_v [2];
  logic [31:0] exp_d [2];
  int          exp_p [2];
  bit          exp_cf;
  bit          exp_af;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_reset();
    lq.delete();
    run_cnt = 0;
    exp_cf  = 1'b0;
    exp_af  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_v[d] = 1'b0;
      exp_d[d] = '0;
      exp_p[d] = 0;
    end
  endfunction

  function automatic void model_edge();
    int unsigned idx;
    bit          oob;
    bit          hon;
    ld_t         keep [$];
    cyc++;
    if (!reset) begin
      run_cnt = 0;
      return;
    end
    run_cnt++;
    hon    = (run_cnt >= 2);
    idx    = int'(addressIn[31:2]);
    oob    = CHECK && (idx >= DEPTH);
    exp_cf = hon && storeIn && loadIn;
    exp_af = hon && (storeIn || loadIn) && oob;
    if (hon && loadIn && !storeIn)
      for (int d = 0; d < 2; d++) lq.push_back('{d, cyc + lat_of[d] - 1, idx % DEPTH, oob});
    for (int d = 0; d < 2; d++) begin
      exp_v[d] = 1'b0;
      exp_p[d] = 0;
    end
    foreach (lq[j]) begin
      exp_p[lq[j].dut]++;
      if (lq[j].due == cyc) begin
        exp_v[lq[j].dut] = 1'b1;
        exp_d[lq[j].dut] = lq[j].oob ? 32'h0 : mmem[lq[j].widx];
      end else begin
        keep.push_back(lq[j]);
      end
    end
    lq = keep;
    if (hon && storeIn && !oob)
      for (int b = 0; b < 4; b++)
        if (byteSelect[b]) mmem[idx % DEPTH][8*b +: 8] = dataWriteIn[8*b +: 8];
  endfunction

  function automatic void check_model();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("m_valid%0d", d), 32'(rv[d]), 32'(exp_v[d]));
      chk($sformatf("m_data%0d", d), rd[d], exp_d[d]);
      chk($sformatf("m_pend%0d", d), 32'(lp[d]), 32'(exp_p[d]));
      chk($sformatf("m_conf%0d", d), 32'(cf[d]), 32'(exp_cf));
      chk($sformatf("m_fault%0d", d), 32'(af[d]), 32'(exp_af));
    end
  endfunction

  task automatic cycle(input bit st, input bit ld, input logic [31:0] a,
                       input logic [31:0] dw, input logic [3:0] be);
    storeIn = st; loadIn = ld; addressIn = a; dataWriteIn = dw; byteSelect = be;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          st;
    bit          ld;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          v1;
    logic [31:0] d1;
    bit          v3;
    logic [31:0] d3;
    int          p3;
    bit          cf;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(bit st, bit ld, logic [31:0] a, logic [31:0] dw, logic [3:0] be,
                              bit v1, logic [31:0] d1, bit v3, logic [31:0] d3, int p3, bit c);
    vec_t v;
    v.st = st; v.ld = ld; v.addr = a; v.data = dw; v.be = be;
    v.v1 = v1; v.d1 = d1; v.v3 = v3; v.d3 = d3; v.p3 = p3; v.cf = c;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0,            0, 0,            0, 0);
    tbl[1]  = mk(0, 1, 32'h10, 0,            4'h0, 1, 32'hDEADBEEF, 0, 0,            1, 0);
    tbl[2]  = mk(1, 0, 32'h10, 32'h000000AA, 4'h1, 0, 0,            0, 0,            1, 0);
    tbl[3]  = mk(0, 0, 32'h0,  0,            4'h0, 0, 0,            1, 32'hDEADBEAA, 1, 0);
    tbl[4]  = mk(0, 1, 32'h10, 0,            4'h0, 1, 32'hDEADBEAA, 0, 0,            1, 0);
    tbl[5]  = mk(1, 0, 32'h10, 32'h12340000, 4'hC, 0, 0,            0, 0,            1, 0);
    tbl[6]  = mk(0, 1, 32'h10, 0,            4'h0, 1, 32'h1234BEAA, 1, 32'h1234BEAA, 2, 0);
    tbl[7]  = mk(0, 0, 32'h0,  0,            4'h0, 0, 0,            0, 0,            1, 0);
    tbl[8]  = mk(0, 0, 32'h0,  0,            4'h0, 0, 0,            1, 32'h1234BEAA, 1, 0);
    tbl[9]  = mk(1, 0, 32'h0,  32'h11111111, 4'hF, 0, 0,            0, 0,            0, 0);
    tbl[10] = mk(1, 0, 32'h4,  32'h22222222, 4'hF, 0, 0,            0, 0,            0, 0);
    tbl[11] = mk(1, 0, 32'h8,  32'h33333333, 4'hF, 0, 0,            0, 0,            0, 0);
    tbl[12] = mk(0, 1, 32'h0,  0,            4'h0, 1, 32'h11111111, 0, 0,            1, 0);
    tbl[13] = mk(0, 1, 32'h4,  0,            4'h0, 1, 32'h22222222, 0, 0,            2, 0);
    tbl[14] = mk(0, 1, 32'h8,  0,            4'h0, 1, 32'h33333333, 1, 32'h11111111, 3, 0);
    tbl[15] = mk(0, 0, 32'h0,  0,            4'h0, 0, 0,            1, 32'h22222222, 2, 0);
    tbl[16] = mk(0, 0, 32'h0,  0,            4'h0, 0, 0,            1, 32'h33333333, 1, 0);
    tbl[17] = mk(0, 0, 32'h0,  0,            4'h0, 0, 0,            0, 0,            0, 0);
    tbl[18] = mk(1, 1, 32'h20, 32'h55,       4'hF, 0, 0,            0, 0,            0, 1);
    tbl[19] = mk(0, 0, 32'h0,  0,            4'h0, 0, 0,            0, 0,            0, 0);
    tbl[20] = mk(0, 1, 32'h20, 0,            4'h0, 1, 32'h55,       0, 0,            1, 0);
    tbl[21] = mk(0, 0, 32'h0,  0,            4'h0, 0, 0,            0, 0,            1, 0);
    tbl[22] = mk(0, 0, 32'h0,  0,            4'h0, 0, 0,            1, 32'h55,       1, 0);
  end

  // ---------------- test sequence ----------------
  initial begin
    int unsigned widx;
    model_reset();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;

    // reset state
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_data", rd[d], 32'h0);
      chk("rst_valid", 32'(rv[d]), 32'h0);
      chk("rst_pend", 32'(lp[d]), 32'h0);
    end
    idle(); idle();
    #2 reset = 1'b1;
    idle(); idle();

    // clear the whole array so every later load has a known answer
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'hF);

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].st, tbl[i].ld, tbl[i].addr, tbl[i].data, tbl[i].be);
      chk($sformatf("t%0d_v1", i), 32'(rv[0]), 32'(tbl[i].v1));
      if (tbl[i].v1) chk($sformatf("t%0d_d1", i), rd[0], tbl[i].d1);
      chk($sformatf("t%0d_v3", i), 32'(rv[1]), 32'(tbl[i].v3));
      if (tbl[i].v3) chk($sformatf("t%0d_d3", i), rd[1], tbl[i].d3);
      chk($sformatf("t%0d_p3", i), 32'(lp[1]), 32'(tbl[i].p3));
      chk($sformatf("t%0d_cf", i), 32'(cf[0]), 32'(tbl[i].cf));
    end

    // out-of-range access at 0x1000 (word 1024)
    cycle(1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, 4'hF);
    chk("oob_st_fault", 32'(af[0]), 32'(CHECK));
    cycle(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    chk("oob_w0_valid", 32'(rv[0]), 32'h1);
    chk("oob_w0_data", rd[0], CHECK ? 32'h11111111 : 32'hCAFEF00D);
    chk("oob_w0_fault", 32'(af[0]), 32'h0);
    cycle(1'b0, 1'b1, 32'h1000, 32'h0, 4'h0);
    chk("oob_ld_valid", 32'(rv[0]), 32'h1);
    chk("oob_ld_data", rd[0], CHECK ? 32'h0 : 32'hCAFEF00D);
    chk("oob_ld_fault", 32'(af[0]), 32'(CHECK));
    idle(); idle(); idle();

    // reset with a load in flight in the latency-3 instance
    cycle(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    idle();
    #2 reset = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("ar_data", rd[d], 32'h0);
      chk("ar_valid", 32'(rv[d]), 32'h0);
      chk("ar_pend", 32'(lp[d]), 32'h0);
      chk("ar_conf", 32'(cf[d]), 32'h0);
    end
    cycle(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF);
    chk("ar_inflight_v3", 32'(rv[1]), 32'h0);
    idle(); idle();
    #2 reset = 1'b1;
    cycle(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF);
    chk("rel_first_conf", 32'(cf[0]), 32'h0);
    cycle(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    chk("rel_second_v1", 32'(rv[0]), 32'h1);
    chk("rel_second_d1", rd[0], 32'h1234BEAA);
    idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("rel_v3", 32'(rv[1]), 32'h1);
    chk("rel_d3", rd[1], 32'h1234BEAA);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      widx = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) widx = widx + DEPTH;
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            32'(widx * 4) | 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
    end
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Word-organised, byte-lane-enabled data RAM that sits on the RAM side of the CPU memory controller. It answers the controller's `ramStore`/`ramLoad` requests, and commits stores per byte lane under `byteSelect`. Read data returns through a fixed-latency load pipeline with a `readValid` strobe, so the controller can handle load data that arrives later than the request.

## Interface
Parameters:
- `DATA_WIDTH`, default `DATA_WIDTH` global (32): bus width. Must be 32, which gives 4 byte lanes.
- `DEPTH_WORDS`, default 1024: number of 32-bit words. Must be a power of two, at least 2.
- `READ_LATENCY`, default 1: number of cycles from load sample to `readValid`. Legal range 1..4.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `addressIn`  in  32  byte address. Word index is `addressIn[31:2]`; bits [1:0] are ignored.
- `dataWriteIn`  in  32  lane-arranged store data.
- `byteSelect`  in  4  per-lane write enable. Bit i enables byte `[8i+7:8i]`.
- `storeIn`  in  1  store request, sampled each rising edge.
- `loadIn`  in  1  load request, sampled each rising edge.
- `dataReadOut`  out  32  full word read (raw, not lane-shifted).
- `readValid`  out  1  one-cycle strobe marking `dataReadOut` valid.
- `loadsPending`  out  3  count of loads in flight (0..READ_LATENCY).
- `requestConflict`  out  1  one-cycle strobe: `storeIn` and `loadIn` were both high.
- `accessFault`  out  1  one-cycle strobe for an out-of-range access. Present only with `RAM_BOUNDS_CHECK_EN`.

## Operation
- Store: when `storeIn` is high at an edge, each lane with `byteSelect[i]=1` is written. Other lanes keep their value. A store with `byteSelect=0` does nothing.
- Load: when `loadIn` is high (and `storeIn` is low) at an edge, the word index enters the load pipeline. The array is read at the final stage, so a store sampled before that stage is visible to the load (read-after-write coherent).
- Simultaneous store and load: the store executes, the load is dropped, and `requestConflict` pulses for one cycle. `loadsPending` does not change.
- Load pipeline: READ_LATENCY stages, each holding a valid bit and a word index. It accepts one load per cycle and is fully pipelined with no backpressure.
- `loadsPending`:
  - Increments on load accept.
  - Decrements on `readValid`.
  - Both in the same cycle: unchanged.
  - Never exceeds READ_LATENCY.
- `dataReadOut` holds its last value between `readValid` pulses.
- Reset (asserted asynchronously):
  - Output values: `dataReadOut`=0, `readValid`=0, `loadsPending`=0, `requestConflict`=0, `accessFault`=0.
  - All pipeline valid bits are cleared, so in-flight loads are discarded and produce no `readValid`.
  - Array contents are not reset.
- Requests present while `reset` is low are ignored.

## Timing
- A load sampled at edge k gives `readValid=1` and valid `dataReadOut` during the cycle after edge k+READ_LATENCY-1.
- READ_LATENCY=1: data appears the cycle right after the request edge.
- A store sampled at edge k is visible to any load whose final pipeline stage executes at edge k+1 or later.
- Back-to-back loads each cycle give back-to-back `readValid` pulses with the same latency.
- `requestConflict` and `accessFault` are registered and assert the cycle after the offending edge.
- Reset deassertion is synchronised internally; the first request is honoured at the second rising edge after deassertion.

## Configuration
- `RAM_BOUNDS_CHECK_EN` defined:
  - A word index ≥ DEPTH_WORDS raises `accessFault` for one cycle.
  - Out-of-range stores are suppressed.
  - Out-of-range loads still travel the pipeline and return `dataReadOut=0` with `readValid`.
- `RAM_BOUNDS_CHECK_EN` undefined:
  - The `accessFault` port is absent.
  - The index wraps modulo DEPTH_WORDS (low log2(DEPTH_WORDS) bits are used).

## Structure
- Shared package (global include): DATA_WIDTH, lane count (4), byte width (8), max READ_LATENCY (4), and the `loadsPending` width.
- One sub-module, `ram_load_pipe`: a parameterised valid/index shift pipeline that also maintains `loadsPending`.
- The array and lane write logic stay in the top module.

## Test plan
- Store 0xDEADBEEF to 0x10 with byteSelect=4'b1111, then load 0x10 → `readValid` after READ_LATENCY cycles with `dataReadOut`=0xDEADBEEF.
- After word 0x10=0xDEADBEEF, store 0x000000AA with byteSelect=4'b0001, then load 0x10 → 0xDEADBEAA. Then store 0x12340000 with byteSelect=4'b1100, then load 0x10 → 0x1234BEAA.
- READ_LATENCY=3: loads to 0x0, 0x4, 0x8 on consecutive cycles → three consecutive `readValid` pulses, in order. `loadsPending` peaks at 3, then returns to 0.
- `storeIn` and `loadIn` both high, address 0x20, data 0x55 → word updated to 0x55, no `readValid`, `requestConflict` pulses once.
- READ_LATENCY=2: issue a load, then assert `reset` one cycle later → `readValid` never asserts, all outputs read 0, and array contents are preserved on the next load.
- `RAM_BOUNDS_CHECK_EN`, DEPTH_WORDS=1024: store to 0x1000 → `accessFault` pulses and word 0 is unchanged. Load from 0x1000 → `readValid` with 0x0. Without the macro, the same store overwrites word 0.
